// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - shared types and default cadence tables for the buzzer arbiter
//
// Contents:
//   state_t       arbiter state encoding (IDLE, ON, OFF, GAP)
//   CNT_W         cadence counter width in ms
//   DEF_N         default number of requesters
//   DEF_ON_TAB    packed on-time per requester, requester i at [i*CNT_W +: CNT_W]
//   DEF_OFF_TAB   packed off-time per requester, 0 = continuous tone
//   DEF_GAP_MS    silent cycles inserted on every ownership change
//   onehot()      index to one-hot vector
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int CNT_W = 10;
    localparam int DEF_N = 4;

    // Requester 0 (fire) is the rightmost field of each table.
    localparam logic [DEF_N*CNT_W-1:0] DEF_ON_TAB  = {10'd30, 10'd200, 10'd100, 10'd256};
    localparam logic [DEF_N*CNT_W-1:0] DEF_OFF_TAB = {10'd0,  10'd200, 10'd400, 10'd256};
    localparam int DEF_GAP_MS = 20;

    function automatic logic [31:0] onehot(input int idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/buzzer_prio_enc.sv
// rtl/buzzer_prio_enc.sv - lowest-index-first priority encoder
//
// Ports:
//   REQ    in   N     request vector, bit 0 has highest priority
//   VALID  out  1     at least one REQ bit is set
//   IDX    out  ID_W  index of the lowest set bit, 0 when none
module buzzer_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    REQ,
    output logic            VALID,
    output logic [ID_W-1:0] IDX
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        VALID = 1'b0;
        IDX   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                VALID = 1'b1;
                IDX   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority owner of the piezo buzzer with per-source beep cadence
//
// Ports:
//   CLK1K      in   1          1 kHz clock, one cycle = 1 ms
//   RST        in   1          synchronous active-high reset
//   REQ        in   N          level request per alarm source, bit 0 highest priority
//   MUTE       in   1          silences BUZ_OUT only; arbitration and cadence keep running
//   GNT        out  N          registered one-hot grant, zero when nobody owns the buzzer
//   ACTIVE_ID  out  clog2(N)   current owner index (held through GAP), 0 when idle
//   BUSY       out  1          high whenever the arbiter is not idle
//   BUZ_OUT    out  1          registered buzzer drive, 500 Hz tone during on-phases
module buzzer_arbiter #(
    parameter int                 N       = buzzer_pkg::DEF_N,
    parameter int                 CNT_W   = buzzer_pkg::CNT_W,
    parameter logic [N*CNT_W-1:0] ON_TAB  = buzzer_pkg::DEF_ON_TAB,
    parameter logic [N*CNT_W-1:0] OFF_TAB = buzzer_pkg::DEF_OFF_TAB,
    parameter int                 GAP_MS  = buzzer_pkg::DEF_GAP_MS
) (
    input  logic                 CLK1K,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic                 MUTE,
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] ACTIVE_ID,
    output logic                 BUSY,
    output logic                 BUZ_OUT
);

    import buzzer_pkg::*;

    localparam int ID_W = $clog2(N);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              tone;

    logic              sel_valid;
    logic [ID_W-1:0]   sel_idx;
    logic [N-1:0]      own_mask;
    logic              own_valid;
    logic [ID_W-1:0]   own_idx;
    logic              keep;

    logic [CNT_W-1:0]  on_len;
    logic [CNT_W-1:0]  off_len;
    logic [CNT_W-1:0]  on_end;
    logic              on_last;
    logic              off_last;
    logic              gap_last;

    buzzer_prio_enc #(.N(N), .ID_W(ID_W)) u_sel (
        .REQ   (REQ),
        .VALID (sel_valid),
        .IDX   (sel_idx)
    );

    // Requests at or above the owner's priority. The lowest set bit of this
    // vector tells us everything: none set means the owner released, a bit
    // below the owner means preemption, the owner itself means keep going.
    always_comb begin
        own_mask = '0;
        for (int i = 0; i < N; i++) begin
            own_mask[i] = REQ[i] && (i <= int'(ACTIVE_ID));
        end
    end

    buzzer_prio_enc #(.N(N), .ID_W(ID_W)) u_own (
        .REQ   (own_mask),
        .VALID (own_valid),
        .IDX   (own_idx)
    );

    assign keep = own_valid && (own_idx == ACTIVE_ID);

    assign on_len  = ON_TAB[int'(ACTIVE_ID)*CNT_W +: CNT_W];
    assign off_len = OFF_TAB[int'(ACTIVE_ID)*CNT_W +: CNT_W];

    // An on-time of 0 is illegal; it behaves as a single-cycle on-phase.
    assign on_end   = (on_len == '0) ? '0 : on_len - CNT_W'(1);
    assign on_last  = (cnt == on_end);
    assign off_last = (cnt == off_len - CNT_W'(1));
    assign gap_last = (cnt == CNT_W'(GAP_MS - 1));

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            tone      <= 1'b0;
            GNT       <= '0;
            ACTIVE_ID <= '0;
            BUSY      <= 1'b0;
            BUZ_OUT   <= 1'b0;
        end else begin
            tone <= ~tone;
            case (state)
                IDLE: begin
                    BUZ_OUT <= 1'b0;
                    cnt     <= '0;
                    if (sel_valid) begin
                        state     <= ON;
                        GNT       <= N'(onehot(int'(sel_idx)));
                        ACTIVE_ID <= sel_idx;
                        BUSY      <= 1'b1;
                    end else begin
                        GNT       <= '0;
                        ACTIVE_ID <= '0;
                        BUSY      <= 1'b0;
                    end
                end

                ON: begin
                    if (!keep) begin
                        state   <= GAP;
                        GNT     <= '0;
                        cnt     <= '0;
                        BUZ_OUT <= 1'b0;
                    end else begin
                        BUZ_OUT <= tone & ~MUTE;
                        if (on_last) begin
                            cnt <= '0;
                            // Zero off-time keeps the tone running without a silent phase.
                            if (off_len != '0) begin
                                state <= OFF;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                OFF: begin
                    BUZ_OUT <= 1'b0;
                    if (!keep) begin
                        state <= GAP;
                        GNT   <= '0;
                        cnt   <= '0;
                    end else if (off_last) begin
                        state <= ON;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    // Requests are only looked at once the full gap has elapsed.
                    BUZ_OUT <= 1'b0;
                    if (gap_last) begin
                        cnt <= '0;
                        if (sel_valid) begin
                            state     <= ON;
                            GNT       <= N'(onehot(int'(sel_idx)));
                            ACTIVE_ID <= sel_idx;
                        end else begin
                            state     <= IDLE;
                            ACTIVE_ID <= '0;
                            BUSY      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    GNT     <= '0;
                    BUSY    <= 1'b0;
                    BUZ_OUT <= 1'b0;
                end
            endcase
        end
    end

endmodule
